// File: rtl/mips_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } mdState_t;

endpackage

// File: rtl/mul_div_datapath.sv
// Shared accumulator/remainder registers with one shift-add or restoring-subtract step per cycle.
// The divide step exists only when MUL_DIV_DIV_EN is defined.
module mul_div_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
`ifdef MUL_DIV_DIV_EN
    input  logic             isDiv,
`endif
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] accHi,
    output logic [WIDTH-1:0] accLo
);

    // upper: product high half (multiply) or partial remainder (divide)
    // lower: multiplier being consumed, or dividend shifting out / quotient shifting in
    logic [WIDTH:0]   upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   nextUpper;
    logic [WIDTH-1:0] nextLower;
`ifdef MUL_DIV_DIV_EN
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remSub;
`endif

    always_comb begin
        mulSum    = upper + (lower[0] ? {1'b0, divisor} : '0);
        nextUpper = {1'b0, mulSum[WIDTH:1]};
        nextLower = {mulSum[0], lower[WIDTH-1:1]};
`ifdef MUL_DIV_DIV_EN
        remShift  = {upper[WIDTH-1:0], lower[WIDTH-1]};
        remSub    = remShift - {1'b0, divisor};
        if (isDiv) begin
            if (remShift < {1'b0, divisor}) begin
                nextUpper = remShift;
                nextLower = {lower[WIDTH-2:0], 1'b0};
            end else begin
                nextUpper = remSub;
                nextLower = {lower[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upper   <= '0;
            lower   <= '0;
            divisor <= '0;
        end else if (load) begin
            upper   <= '0;
            lower   <= opA;
            divisor <= opB;
        end else if (step) begin
            upper   <= nextUpper;
            lower   <= nextLower;
        end
    end

    assign accHi = upper[WIDTH-1:0];
    assign accLo = lower;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; divide support is built only with MUL_DIV_DIV_EN.
// States: MD_IDLE | waiting for start ; MD_CALC | WIDTH iterations ; MD_FIX | sign fix, write hi/lo, pulse done
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    mdState_t         state, stateNext;
    logic [5:0]       cnt;
    logic             divOp, negRes, busyNext;
    logic             accept, isDivIn, isSignedIn;
    logic [WIDTH-1:0] magA, magB, dpHi, dpLo, hiNext, loNext;
    logic [2*WIDTH-1:0] prod;
`ifdef MUL_DIV_DIV_EN
    logic             negRem, zeroDiv, dbzReg;
    logic [WIDTH-1:0] rsRaw;
`endif

    assign accept     = (state == MD_IDLE) && start;
    assign isDivIn    = op[1];
    assign isSignedIn = (op == OP_MULT) || (op == OP_DIV);
    assign magA       = (isSignedIn && rs[WIDTH-1]) ? -rs : rs;
    assign magB       = (isSignedIn && rt[WIDTH-1]) ? -rt : rt;

    mul_div_datapath #(.WIDTH(WIDTH)) uDatapath (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (state == MD_CALC),
`ifdef MUL_DIV_DIV_EN
        .isDiv (divOp),
`endif
        .opA   (magA),
        .opB   (magB),
        .accHi (dpHi),
        .accLo (dpLo)
    );

    always_comb begin
        stateNext = state;
        case (state)
            MD_IDLE: begin
                if (start) begin
`ifdef MUL_DIV_DIV_EN
                    stateNext = MD_CALC;
`else
                    stateNext = isDivIn ? MD_FIX : MD_CALC;
`endif
                end
            end
            MD_CALC: if (cnt == 6'd0) stateNext = MD_FIX;
            MD_FIX:  stateNext = MD_IDLE;
            default: stateNext = MD_IDLE;
        endcase
        // busy stays high through the FIX cycle only when arriving from CALC
        busyNext = (stateNext == MD_CALC) || (state == MD_CALC);
    end

    always_comb begin
        prod   = {dpHi, dpLo};
        hiNext = hi;
        loNext = lo;
        if (!divOp) begin
            {hiNext, loNext} = negRes ? -prod : prod;
        end
`ifdef MUL_DIV_DIV_EN
        else if (zeroDiv) begin
            hiNext = rsRaw;
            loNext = '1;
        end else begin
            hiNext = negRem ? -dpHi : dpHi;
            loNext = negRes ? -dpLo : dpLo;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MD_IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            divOp  <= 1'b0;
            negRes <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= busyNext;
            done <= (state == MD_FIX);
            if (accept) begin
                cnt    <= 6'(WIDTH - 1);
                divOp  <= isDivIn;
                negRes <= isSignedIn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
            end else if (state == MD_CALC) begin
                cnt <= cnt - 6'd1;
            end
            if (state == MD_FIX) begin
                hi <= hiNext;
                lo <= loNext;
            end
        end
    end

`ifdef MUL_DIV_DIV_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            negRem  <= 1'b0;
            zeroDiv <= 1'b0;
            rsRaw   <= '0;
            dbzReg  <= 1'b0;
        end else if (accept) begin
            negRem  <= isSignedIn & rs[WIDTH-1];
            zeroDiv <= (rt == '0);
            rsRaw   <= rs;
            dbzReg  <= 1'b0;
        end else if (state == MD_FIX) begin
            dbzReg  <= divOp & zeroDiv;
        end
    end

    assign div_by_zero = dbzReg;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mips_pkg::*;

`ifdef MUL_DIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // returns {div_by_zero, hi, lo}; prevHi/prevLo are what hi/lo hold if the op leaves them alone
    function automatic logic [64:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] prevHi,
                                             input logic [31:0] prevLo);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (o == 2'b00) begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            return {1'b0, p};
        end
        if (o == 2'b01) begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (!DIV_EN) return {1'b0, prevHi, prevLo};
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // call at a negedge; returns at the negedge where done is high so the next call is back-to-back
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] e;
        int expLat;
        int edges;
        e = refModel(o, a, b, expHi, expLo);
        expLat = (o[1] && !DIV_EN) ? 1 : 33;
        op = o; rs = a; rt = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":done_after_accept"}, 64'(done), 64'd0);
        check({tag, ":dbz_cleared"}, 64'(div_by_zero), 64'd0);
        check({tag, ":busy_after_accept"}, 64'(busy), 64'(expLat > 1));
        edges = 0;
        do begin
            if (edges > 0 || done !== 1'b1) begin
                @(posedge clk); #1;
                edges++;
            end
        end while (done !== 1'b1 && edges < 60);
        check({tag, ":latency"}, 64'(edges), 64'(expLat));
        check({tag, ":hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, ":lo"}, 64'(lo), 64'(e[31:0]));
        check({tag, ":dbz"}, 64'(div_by_zero), 64'(e[64]));
        check({tag, ":busy_at_done"}, 64'(busy), 64'd0);
        expHi = e[63:32];
        expLo = e[31:0];
        @(negedge clk);
    endtask

    initial begin
        logic [64:0] e;
        int dones;
        logic [31:0] capHi, capLo, a, b;
        logic [1:0] o;

        #12;
        check("reset:hi", 64'(hi), 64'd0);
        check("reset:lo", 64'(lo), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7);
        runOp("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        runOp("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        runOp("div_minbyneg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("divu_100by0", OP_DIVU, 32'd100, 32'd0);
        runOp("multu_after_dbz", OP_MULTU, 32'd3, 32'd5);
        runOp("mult_pos_neg", OP_MULT, 32'd123456, 32'hFFFF_0000);

        // a start pulsed mid-CALC must neither disturb nor queue
        @(negedge clk);
        e = refModel(OP_MULTU, 32'd123456, 32'd789, expHi, expLo);
        op = OP_MULTU; rs = 32'd123456; rt = 32'd789; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = OP_MULT; rs = 32'd5; rt = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; capHi = '0; capLo = '0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                capHi = hi;
                capLo = lo;
            end
        end
        check("ignore_start:done_count", 64'(dones), 64'd1);
        check("ignore_start:hi", 64'(capHi), 64'(e[63:32]));
        check("ignore_start:lo", 64'(capLo), 64'(e[31:0]));
        expHi = e[63:32];
        expLo = e[31:0];

        // asynchronous reset at iteration 10
        @(negedge clk);
        op = OP_MULTU; rs = 32'hDEAD_BEEF; rt = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset:hi", 64'(hi), 64'd0);
        check("midreset:lo", 64'(lo), 64'd0);
        check("midreset:busy", 64'(busy), 64'd0);
        check("midreset:done", 64'(done), 64'd0);
        check("midreset:dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        expHi = '0;
        expLo = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset:idle_busy", 64'(busy), 64'd0);
            check("midreset:idle_done", 64'(done), 64'd0);
        end
        runOp("multu_6x7", OP_MULTU, 32'd6, 32'd7);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(2, 1000));
                default: b = $urandom;
            endcase
            runOp("random", o, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
